// File: rtl/key_sched_pkg.sv
// Shared types and helpers for the key range scheduler.
package key_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DISPATCH,
        ST_DRAIN,
        ST_FOUND,
        ST_EXHAUSTED
    } sched_state_t;

    localparam int unsigned KEY_WIDTH_DEFAULT  = 24;
    localparam int unsigned CHUNK_SIZE_DEFAULT = 4096;
    localparam int unsigned MAX_CORES          = 16;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic int unsigned lowest_set(input logic [MAX_CORES-1:0] vec);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = MAX_CORES; i > 0; i--) begin
            if (vec[i-1]) idx = i - 1;
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_range_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from a request mask, search starts at
// the pointer, pointer moves past the winner when the grant is accepted.
module rr_arbiter #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] req,
    input  logic         accept,
    output logic [N-1:0] gnt
);

    localparam int unsigned PW = $clog2(N);

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_n;

    // Pick the first requester at or after the pointer, wrapping around.
    always_comb begin
        int unsigned idx;
        logic        hit;
        gnt   = '0;
        ptr_n = ptr;
        hit   = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!hit && req[idx]) begin
                hit      = 1'b1;
                gnt[idx] = 1'b1;
                ptr_n    = (idx + 1 == N) ? '0 : PW'(idx + 1);
            end
        end
    end

    // Pointer only advances when the scheduler actually issues the grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    ptr <= '0;
        else if (accept) ptr <= ptr_n;
    end

endmodule

// File: rtl/key_range_scheduler.sv
// Key range scheduler: hands fixed-size key chunks to requesting RC4 cores,
// tracks outstanding chunks, latches the first match and drives a common stop.
// Optional macro KEY_SCHED_PERF_EN adds the search_cycles counter output.
module key_range_scheduler
    import key_sched_pkg::*;
#(
    parameter int unsigned CORE_COUNT = 8,
    parameter int unsigned KEY_WIDTH  = KEY_WIDTH_DEFAULT,
    parameter int unsigned KEY_SPACE  = 4194304,
    parameter int unsigned CHUNK_SIZE = CHUNK_SIZE_DEFAULT
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            start,
    input  logic                            abort,
    input  logic [CORE_COUNT-1:0]           core_req,
    input  logic [CORE_COUNT-1:0]           core_chunk_done,
    input  logic [CORE_COUNT-1:0]           core_found,
    input  logic [CORE_COUNT*KEY_WIDTH-1:0] core_found_key,
    output logic [CORE_COUNT-1:0]           grant,
    output logic [KEY_WIDTH-1:0]            chunk_base,
    output logic                            stop,
    output logic                            busy,
    output logic                            found,
    output logic                            exhausted,
    output logic [KEY_WIDTH-1:0]            found_key,
    output logic [$clog2(CORE_COUNT)-1:0]   found_core
`ifdef KEY_SCHED_PERF_EN
    ,
    output logic [31:0]                     search_cycles
`endif
);

    localparam int unsigned IW  = $clog2(CORE_COUNT);
    localparam int unsigned NKW = KEY_WIDTH + 1;
    localparam logic [NKW-1:0] LAST_BASE = NKW'(KEY_SPACE - CHUNK_SIZE);
    localparam logic [NKW-1:0] STEP      = NKW'(CHUNK_SIZE);

    sched_state_t            state, state_n;
    logic [NKW-1:0]          next_key, next_key_n;
    logic [CORE_COUNT-1:0]   outstanding, outstanding_n;
    logic [CORE_COUNT-1:0]   arb_req, arb_gnt, grant_n;
    logic                    arb_accept;
    logic [KEY_WIDTH-1:0]    chunk_base_n, found_key_n;
    logic [IW-1:0]           found_core_n;
    logic                    found_n, exhausted_n, run_n;

    assign arb_req = core_req & ~outstanding;

    rr_arbiter #(.N(CORE_COUNT)) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (arb_req),
        .accept  (arb_accept),
        .gnt     (arb_gnt)
    );

    // Next-state and next-output logic; found beats abort beats done beats grant.
    always_comb begin
        int unsigned win;
        state_n       = state;
        next_key_n    = next_key;
        outstanding_n = outstanding;
        grant_n       = '0;
        chunk_base_n  = chunk_base;
        found_key_n   = found_key;
        found_core_n  = found_core;
        found_n       = found;
        exhausted_n   = exhausted;
        arb_accept    = 1'b0;
        win           = lowest_set(MAX_CORES'(core_found));

        unique case (state)
            ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
                if (start) begin
                    state_n       = ST_DISPATCH;
                    next_key_n    = '0;
                    outstanding_n = '0;
                    found_n       = 1'b0;
                    exhausted_n   = 1'b0;
                    found_key_n   = '0;
                    found_core_n  = '0;
                end
            end
            ST_DISPATCH, ST_DRAIN: begin
                if (|core_found) begin
                    state_n      = ST_FOUND;
                    found_n      = 1'b1;
                    found_key_n  = core_found_key[win*KEY_WIDTH +: KEY_WIDTH];
                    found_core_n = IW'(win);
                end else if (abort) begin
                    state_n = ST_IDLE;
                end else begin
                    // Done pulses from cores without a chunk fall out of the AND.
                    outstanding_n = outstanding & ~core_chunk_done;
                    if (state == ST_DISPATCH) begin
                        if (|arb_req) begin
                            arb_accept    = 1'b1;
                            grant_n       = arb_gnt;
                            chunk_base_n  = next_key[KEY_WIDTH-1:0];
                            outstanding_n = outstanding_n | arb_gnt;
                            next_key_n    = next_key + STEP;
                            if (next_key == LAST_BASE) state_n = ST_DRAIN;
                        end
                    end else if (outstanding_n == '0) begin
                        // Compare against the post-done mask so exhausted rises
                        // on the edge that sees the last done.
                        state_n     = ST_EXHAUSTED;
                        exhausted_n = 1'b1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        run_n = (state_n == ST_DISPATCH) || (state_n == ST_DRAIN);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            next_key    <= '0;
            outstanding <= '0;
            grant       <= '0;
            chunk_base  <= '0;
            stop        <= 1'b1;
            busy        <= 1'b0;
            found       <= 1'b0;
            exhausted   <= 1'b0;
            found_key   <= '0;
            found_core  <= '0;
        end else begin
            state       <= state_n;
            next_key    <= next_key_n;
            outstanding <= outstanding_n;
            grant       <= grant_n;
            chunk_base  <= chunk_base_n;
            stop        <= !run_n;
            busy        <= run_n;
            found       <= found_n;
            exhausted   <= exhausted_n;
            found_key   <= found_key_n;
            found_core  <= found_core_n;
        end
    end

`ifdef KEY_SCHED_PERF_EN
    logic start_accept;
    logic running;

    assign start_accept = start && (state == ST_IDLE || state == ST_FOUND || state == ST_EXHAUSTED);
    assign running      = (state == ST_DISPATCH) || (state == ST_DRAIN);

    // Saturating count of cycles spent searching, restarted on an accepted start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                              search_cycles <= '0;
        else if (start_accept)                     search_cycles <= '0;
        else if (running && search_cycles != '1)   search_cycles <= search_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_key_range_scheduler.sv
// Bench for key_range_scheduler: two instances (16- and 8-key chunks over a
// 64-key space, 4 cores) share one stimulus stream and are checked each cycle
// against a chunk-counting model, plus hand-computed literal expectations.
module tb_key_range_scheduler;

    localparam int M_IDLE = 0, M_DISP = 1, M_DRAIN = 2, M_FOUND = 3, M_EXH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, abort;
    logic [3:0]  core_req, core_chunk_done, core_found;
    logic [95:0] core_found_key;

    logic [3:0]  a_grant, b_grant;
    logic [23:0] a_base, b_base, a_key, b_key;
    logic        a_stop, b_stop, a_busy, b_busy, a_found, b_found, a_exh, b_exh;
    logic [1:0]  a_core, b_core;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    key_range_scheduler #(.CORE_COUNT(4), .KEY_WIDTH(24), .KEY_SPACE(64), .CHUNK_SIZE(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .core_req(core_req), .core_chunk_done(core_chunk_done),
        .core_found(core_found), .core_found_key(core_found_key),
        .grant(a_grant), .chunk_base(a_base), .stop(a_stop), .busy(a_busy),
        .found(a_found), .exhausted(a_exh), .found_key(a_key), .found_core(a_core)
    );

    key_range_scheduler #(.CORE_COUNT(4), .KEY_WIDTH(24), .KEY_SPACE(64), .CHUNK_SIZE(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .core_req(core_req), .core_chunk_done(core_chunk_done),
        .core_found(core_found), .core_found_key(core_found_key),
        .grant(b_grant), .chunk_base(b_base), .stop(b_stop), .busy(b_busy),
        .found(b_found), .exhausted(b_exh), .found_key(b_key), .found_core(b_core)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: index 0 = 16-key chunks, 1 = 8-key chunks
    int          m_mode[2], m_handed[2], m_rr[2];
    logic [3:0]  m_out[2], e_grant[2];
    logic [23:0] e_base[2], e_key[2];
    logic [1:0]  e_core[2];
    logic        e_found[2], e_exh[2];

    function automatic int csz(input int m);
        return (m == 0) ? 16 : 8;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_mode[m] = M_IDLE; m_handed[m] = 0; m_rr[m] = 0; m_out[m] = '0;
            e_grant[m] = '0; e_base[m] = '0; e_key[m] = '0; e_core[m] = '0;
            e_found[m] = 1'b0; e_exh[m] = 1'b0;
        end
    endtask

    task automatic model_step(input int m);
        logic [3:0] prev;
        int cand;
        bit gave;
        e_grant[m] = '0;
        if (m_mode[m] == M_IDLE || m_mode[m] == M_FOUND || m_mode[m] == M_EXH) begin
            if (start) begin
                m_mode[m] = M_DISP; m_handed[m] = 0; m_out[m] = '0;
                e_found[m] = 1'b0; e_exh[m] = 1'b0; e_key[m] = '0; e_core[m] = '0;
            end
        end else if (core_found != 4'b0) begin
            cand = 0;
            for (int i = 3; i >= 0; i--) if (core_found[i]) cand = i;
            m_mode[m] = M_FOUND; e_found[m] = 1'b1;
            e_core[m] = 2'(cand);
            e_key[m]  = core_found_key[cand*24 +: 24];
        end else if (abort) begin
            m_mode[m] = M_IDLE;
        end else begin
            prev = m_out[m];
            m_out[m] = m_out[m] & ~core_chunk_done;
            if (m_mode[m] == M_DISP) begin
                gave = 0;
                for (int j = 0; j < 4; j++) begin
                    cand = (m_rr[m] + j) % 4;
                    if (!gave && core_req[cand] && !prev[cand]) begin
                        gave = 1;
                        e_grant[m][cand] = 1'b1;
                        e_base[m] = 24'(m_handed[m] * csz(m));
                        m_handed[m]++;
                        m_out[m][cand] = 1'b1;
                        m_rr[m] = (cand + 1) % 4;
                        if (m_handed[m] == 64 / csz(m)) m_mode[m] = M_DRAIN;
                    end
                end
            end else if (m_out[m] == 4'b0) begin
                m_mode[m] = M_EXH; e_exh[m] = 1'b1;
            end
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
    end

    task automatic cmp_dut(input int m, input logic [3:0] g, input logic [23:0] base,
                           input logic st, input logic bz, input logic fd, input logic ex,
                           input logic [23:0] key, input logic [1:0] core);
        logic run;
        run = (m_mode[m] == M_DISP) || (m_mode[m] == M_DRAIN);
        chk($sformatf("dut%0d.grant", m),      32'(g),    32'(e_grant[m]));
        chk($sformatf("dut%0d.chunk_base", m), 32'(base), 32'(e_base[m]));
        chk($sformatf("dut%0d.stop", m),       32'(st),   32'(!run));
        chk($sformatf("dut%0d.busy", m),       32'(bz),   32'(run));
        chk($sformatf("dut%0d.found", m),      32'(fd),   32'(e_found[m]));
        chk($sformatf("dut%0d.exhausted", m),  32'(ex),   32'(e_exh[m]));
        chk($sformatf("dut%0d.found_key", m),  32'(key),  32'(e_key[m]));
        chk($sformatf("dut%0d.found_core", m), 32'(core), 32'(e_core[m]));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_dut(0, a_grant, a_base, a_stop, a_busy, a_found, a_exh, a_key, a_core);
            cmp_dut(1, b_grant, b_base, b_stop, b_busy, b_found, b_exh, b_key, b_core);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus
    initial begin
        int seq[4];
        bit got;
        seq = '{2, 0, 3, 1};
        model_reset();
        reset_n = 1'b1; start = 0; abort = 0;
        core_req = '0; core_chunk_done = '0; core_found = '0; core_found_key = '0;
        #2 reset_n = 1'b0;
        #1 chk_en = 1;
        tick(); tick();
        chk("reset.stop", 32'(a_stop), 32'd1);
        chk("reset.busy", 32'(a_busy), 32'd0);
        chk("reset.grant", 32'(a_grant), 32'd0);
        reset_n = 1'b1;
        tick();

        // all cores request: grants 0..3 with bases 0,16,32,48
        start = 1; core_req = 4'hF;
        tick();
        start = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t1.grant%0d", k), 32'(a_grant), 32'(1 << k));
            chk($sformatf("t1.base%0d", k),  32'(a_base),  32'(k * 16));
        end
        tick();
        chk("t1.drain_grant", 32'(a_grant), 32'd0);
        chk("t1.drain_busy",  32'(a_busy),  32'd1);

        // completions out of order: exhausted right after the last one
        core_req = '0;
        for (int k = 0; k < 4; k++) begin
            core_chunk_done = 4'(1 << seq[k]);
            tick();
            core_chunk_done = '0;
            if (k == 2) chk("t2.exh_early", 32'(a_exh), 32'd0);
        end
        chk("t2.exhausted", 32'(a_exh),  32'd1);
        chk("t2.stop",      32'(a_stop), 32'd1);
        chk("t2.busy",      32'(a_busy), 32'd0);

        // restart, fill dut_a into DRAIN, core 2 reports a match
        start = 1; core_req = 4'hF;
        tick();
        start = 0;
        repeat (4) tick();
        core_req = '0;
        core_found = 4'b0100;
        core_found_key[2*24 +: 24] = 24'h00002A;
        tick();
        core_found = '0;
        chk("t3.found",      32'(a_found), 32'd1);
        chk("t3.found_key",  32'(a_key),   32'h2A);
        chk("t3.found_core", 32'(a_core),  32'd2);
        chk("t3.stop",       32'(a_stop),  32'd1);

        // restart clears results; two simultaneous matches, lowest index wins
        start = 1;
        tick();
        start = 0;
        chk("t4.found_clr", 32'(a_found), 32'd0);
        chk("t4.key_clr",   32'(a_key),   32'd0);
        core_req = 4'hF;
        core_found = 4'b1010;
        core_found_key[1*24 +: 24] = 24'h000011;
        core_found_key[3*24 +: 24] = 24'h000033;
        tick();
        core_found = '0; core_req = '0;
        chk("t4.found_core", 32'(a_core),  32'd1);
        chk("t4.found_key",  32'(a_key),   32'h11);
        chk("t4.no_grant",   32'(a_grant), 32'd0);

        // single core with done/re-request loop: dut_b bases 0,8,...,56
        start = 1;
        tick();
        start = 0;
        for (int k = 0; k < 8; k++) begin
            core_req = 4'b0001;
            got = 0;
            for (int w = 0; w < 8 && !got; w++) begin
                tick();
                if (b_grant != 4'b0) got = 1;
            end
            if (!got) begin
                errors++;
                $display("FAIL t5.grant_timeout chunk=%0d actual=none required=grant", k);
            end
            chk($sformatf("t5.grant%0d", k), 32'(b_grant), 32'd1);
            chk($sformatf("t5.base%0d", k),  32'(b_base),  32'(k * 8));
            core_req = '0;
            core_chunk_done = 4'b0001;
            tick();
            core_chunk_done = '0;
        end
        chk("t5.b_exhausted", 32'(b_exh), 32'd1);
        chk("t5.a_exhausted", 32'(a_exh), 32'd1);

        // abort mid-dispatch
        start = 1; core_req = 4'hF;
        tick();
        start = 0;
        tick(); tick();
        abort = 1;
        tick();
        abort = 0;
        chk("t6.abort_busy",  32'(a_busy),  32'd0);
        chk("t6.abort_stop",  32'(a_stop),  32'd1);
        chk("t6.abort_found", 32'(a_found), 32'd0);
        chk("t6.abort_exh",   32'(a_exh),   32'd0);

        // asynchronous reset mid-search
        start = 1;
        tick();
        start = 0;
        tick();
        reset_n = 1'b0;
        #1;
        chk("t6.rst_grant", 32'(a_grant), 32'd0);
        chk("t6.rst_base",  32'(a_base),  32'd0);
        chk("t6.rst_stop",  32'(a_stop),  32'd1);
        chk("t6.rst_busy",  32'(a_busy),  32'd0);
        tick(); tick();
        reset_n = 1'b1;
        start = 1; core_req = 4'hF;
        tick();
        start = 0;
        tick();
        chk("t6.restart_grant", 32'(a_grant), 32'd1);
        chk("t6.restart_base",  32'(a_base),  32'd0);
        core_req = '0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
